// File: rtl/cpu_linux_oci_dct_packer.sv
// OCI DCT trace packer: gathers 2-bit symbols into 30-bit frames with a
// symbol count and presents them under a valid/ready handshake.
module cpu_linux_oci_dct_packer #(
  parameter int SYM_W = 2,
  parameter int NSYM  = 15,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trc_on,
  input  logic                  sym_valid,
  input  logic [SYM_W-1:0]      sym,
  output logic                  sym_ready,
  input  logic                  flush,
  output logic [SYM_W*NSYM-1:0] dct_buffer,
  output logic [CNT_W-1:0]      dct_count,
  output logic                  dct_valid,
  input  logic                  dct_ready,
  output logic                  test_ending
);

  localparam int BUF_W = SYM_W * NSYM;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NSYM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSYM - 1);

  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;
  logic             full_pending;
  logic             flush_pending;
  logic             trc_q;
  logic             armed;

  logic             accept;
  logic             slot_free;
  logic [BUF_W-1:0] acc_with;
  logic [CNT_W-1:0] cnt_with;
  logic             flushing;
  logic             want_emit;
  logic             emit;
  logic             trc_fall;

  // Taking a 15th symbol into a stalled slot would leave nowhere to go.
  assign sym_ready = !(acc_cnt == LAST && dct_valid && !dct_ready)
                   && !full_pending && !flush_pending;

  assign accept    = sym_valid && sym_ready && trc_on;
  assign slot_free = !dct_valid || dct_ready;
  assign cnt_with  = acc_cnt + CNT_W'(accept);
  assign flushing  = (flush || flush_pending) && (cnt_with != '0);
  assign want_emit = (cnt_with == FULL) || flushing;
  assign emit      = want_emit && slot_free;
  assign trc_fall  = trc_q && !trc_on;

  always_comb begin
    acc_with = acc;
    for (int k = 0; k < NSYM; k++) begin
      if (accept && acc_cnt == CNT_W'(k))
        acc_with[k*SYM_W +: SYM_W] = sym;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc           <= '0;
      acc_cnt       <= '0;
      full_pending  <= 1'b0;
      flush_pending <= 1'b0;
      dct_buffer    <= '0;
      dct_count     <= '0;
      dct_valid     <= 1'b0;
      test_ending   <= 1'b0;
      trc_q         <= 1'b0;
      armed         <= 1'b0;
    end else begin
      trc_q       <= trc_on;
      test_ending <= emit && (armed || trc_fall);
      armed       <= emit ? 1'b0 : (armed || trc_fall);
      if (emit) begin
        acc           <= '0;
        acc_cnt       <= '0;
        full_pending  <= 1'b0;
        flush_pending <= 1'b0;
        dct_buffer    <= acc_with;
        dct_count     <= cnt_with;
        dct_valid     <= 1'b1;
      end else begin
        acc           <= acc_with;
        acc_cnt       <= cnt_with;
        full_pending  <= (cnt_with == FULL);
        flush_pending <= flush_pending || flushing;
        if (dct_ready)
          dct_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_linux_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: model frames are queued as symbols
// are accepted and compared as the DUT hands frames over.
module tb_cpu_linux_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on;
  logic        sym_valid;
  logic [1:0]  sym;
  logic        sym_ready;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_ending;

  typedef struct packed {
    logic [29:0] buf_v;
    logic [3:0]  cnt_v;
  } frame_t;

  frame_t      q[$];
  logic [29:0] m_acc;
  int          m_cnt;
  int          checks = 0;
  int          errors = 0;
  int          te_cnt = 0;
  logic [29:0] last_buf;
  logic [3:0]  last_cnt;
  logic        p_valid, p_ready;
  logic [29:0] p_buf;
  logic [3:0]  p_cnt;

  always #5 clk = ~clk;

  cpu_linux_oci_dct_packer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .trc_on      (trc_on),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .sym_ready   (sym_ready),
    .flush       (flush),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .dct_valid   (dct_valid),
    .dct_ready   (dct_ready),
    .test_ending (test_ending)
  );

  // Monitor: transfers, stall stability, test_ending pulses.
  always @(negedge clk) begin
    if (reset_n) begin
      if (test_ending) te_cnt++;
      if (p_valid && !p_ready && dct_valid) begin
        checks++;
        if (dct_buffer !== p_buf || dct_count !== p_cnt) begin
          errors++;
          $display("FAIL stall_stable got %h/%0d want %h/%0d",
                   dct_buffer, dct_count, p_buf, p_cnt);
        end
      end
      if (dct_valid && dct_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame got %h/%0d want none",
                   dct_buffer, dct_count);
        end else begin
          frame_t f;
          f = q.pop_front();
          if (dct_buffer !== f.buf_v || dct_count !== f.cnt_v) begin
            errors++;
            $display("FAIL frame got %h/%0d want %h/%0d",
                     dct_buffer, dct_count, f.buf_v, f.cnt_v);
          end
        end
        last_buf = dct_buffer;
        last_cnt = dct_count;
      end
    end
    p_valid = dct_valid && reset_n;
    p_ready = dct_ready;
    p_buf   = dct_buffer;
    p_cnt   = dct_count;
  end

  function automatic void model_push();
    frame_t f;
    f.buf_v = m_acc;
    f.cnt_v = 4'(m_cnt);
    q.push_back(f);
    m_acc = '0;
    m_cnt = 0;
  endfunction

  task automatic send_sym(input logic [1:0] s, input logic fl);
    int  w    = 0;
    bit  done = 0;
    sym_valid = 1'b1;
    sym       = s;
    flush     = fl;
    while (!done) begin
      @(negedge clk);
      if (sym_ready && trc_on) begin
        m_acc[m_cnt*2 +: 2] = s;
        m_cnt++;
        if (m_cnt == 15 || fl) model_push();
        done = 1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        w++;
        if (w > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout got stalled want accept");
          done = 1;
        end
      end
    end
    sym_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    if (m_cnt > 0) model_push();
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending want 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trc_on = 1'b1; sym_valid = 1'b0;
    sym = '0; flush = 1'b0; dct_ready = 1'b1;
    m_acc = '0; m_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dct_valid, dct_count, dct_buffer, test_ending} !== '0
        || sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset got v%b c%0d b%h te%b rdy%b want 0 0 0 0 1",
               dct_valid, dct_count, dct_buffer, test_ending, sym_ready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 15; k++) send_sym(2'(k), 1'b0);
    checks++;
    if (dct_valid !== 1'b1 || dct_count !== 4'd15) begin
      errors++;
      $display("FAIL latency got v%b c%0d want v1 c15", dct_valid, dct_count);
    end
    drain("b2b");
    checks++;
    if (last_buf !== 30'h24E4E4E4 || last_cnt !== 4'd15) begin
      errors++;
      $display("FAIL b2b_const got %h/%0d want 24e4e4e4/15", last_buf, last_cnt);
    end
  endtask

  task automatic test_partial();
    send_sym(2'b01, 1'b0);
    send_sym(2'b10, 1'b0);
    send_sym(2'b11, 1'b0);
    do_flush();
    drain("partial");
    checks++;
    if (last_buf !== 30'h39 || last_cnt !== 4'd3) begin
      errors++;
      $display("FAIL partial_const got %h/%0d want 39/3", last_buf, last_cnt);
    end
  endtask

  task automatic test_backpressure();
    dct_ready = 1'b0;
    for (int k = 0; k < 28; k++) send_sym(2'($urandom_range(0, 3)), 1'b0);
    @(negedge clk);
    checks++;
    if (sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready28 got %b want 1", sym_ready);
    end
    @(posedge clk);
    #1;
    send_sym(2'($urandom_range(0, 3)), 1'b0);
    @(negedge clk);
    checks++;
    if (sym_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready29 got %b want 0", sym_ready);
    end
    @(posedge clk);
    #1;
    dct_ready = 1'b1;
    send_sym(2'b11, 1'b0);
    drain("bp");
  endtask

  task automatic test_flush_edges();
    do_flush();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dct_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_flush got v%b want v0", dct_valid);
    end
    send_sym(2'b10, 1'b1);
    drain("flush_sym");
    checks++;
    if (last_cnt !== 4'd1 || last_buf !== 30'h2) begin
      errors++;
      $display("FAIL flush_sym got %h/%0d want 2/1", last_buf, last_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 7; k++) send_sym(2'(k + 1), 1'b0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dct_valid, dct_count, dct_buffer, test_ending} !== '0
        || sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got v%b c%0d b%h rdy%b want 0 0 0 1",
               dct_valid, dct_count, dct_buffer, sym_ready);
    end
    m_acc = '0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    do_flush();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dct_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush got v%b want v0", dct_valid);
    end
  endtask

  task automatic test_trc_off();
    checks++;
    if (te_cnt != 0) begin
      errors++;
      $display("FAIL te_early got %0d want 0", te_cnt);
    end
    for (int k = 0; k < 4; k++) send_sym(2'(3 - k), 1'b0);
    trc_on = 1'b0;
    sym_valid = 1'b1;
    sym = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    sym_valid = 1'b0;
    do_flush();
    drain("trc_off");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (last_cnt !== 4'd4 || last_buf !== 30'h1B) begin
      errors++;
      $display("FAIL trc_off_frame got %h/%0d want 1b/4", last_buf, last_cnt);
    end
    checks++;
    if (te_cnt != 1) begin
      errors++;
      $display("FAIL test_ending got %0d pulses want 1", te_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial();
    test_backpressure();
    test_flush_edges();
    test_reset_mid();
    test_trc_off();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
